dram_arbiter: RTL and testbench
===============================

# dram_arbiter

Two-port arbiter and access sequencer for the data RAM. The RAM has a 16-bit word address, 32-bit data, a single word-wide write enable and a one-cycle registered read. This block sits between the core LSU (port 0) and the debug/loader port (port 1). It performs round-robin arbitration, converts byte addresses to word addresses, and does sign/zero-extended sub-word loads. Sub-word stores are done as read-modify-write because the RAM has no byte enables.

## Interface
- `ADDR_W`, 16: RAM word-address width; requester byte address is `ADDR_W+2` bits.
- `DATA_W`, 32: data width; fixed at 32 (lane logic assumes 4 bytes).
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1: clock.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  2: request valid, one bit per port.
- `req_ready`  out  2: request accepted this cycle; at most one bit high.
- `req_we[i]`  in  1 each: 1 = store.
- `req_addr[i]`  in  ADDR_W+2 each: byte address.
- `req_size[i]`  in  2 each: 00 byte, 01 half, 10 word; 11 is treated as word.
- `req_unsigned[i]`  in  1 each: zero-extend loads.
- `req_wdata[i]`  in  32 each: store data, right-aligned.
- `rsp_valid`  out  2: one-cycle response pulse to the owning port.
- `rsp_rdata`  out  32: load result, shared; 0 for stores and errors.
- `rsp_err`  out  1: misaligned access, qualified by `rsp_valid`.
- `mem_a`  out  ADDR_W: RAM word address.
- `mem_we`  out  1: RAM write enable.
- `mem_din`  out  32: RAM write data.
- `mem_spo`  in  32: RAM read data, valid the cycle after `mem_a` is presented.

## Operation
- **States:** IDLE, RD, WR, MERGE, RESP.
- **IDLE:**
  - Grant goes to the valid port. If both ports are valid, grant goes to the port that did not win last (`last_grant`, reset to 1, so port 0 wins the first tie).
  - `req_ready[g]` is asserted combinationally in IDLE only. The handshake completes on `valid & ready`.
  - On handshake, latch the request.
- **Transitions out of IDLE:**
  - Misaligned request (half with `addr[0]`=1, or word with `addr[1:0]`≠0) → RESP with err=1. No RAM access.
  - Load, or sub-word store → RD.
  - Word store → WR.
- **RD:** `mem_a`=`addr[ADDR_W+1:2]`, `mem_we`=0. Next state is MERGE for a store, RESP for a load.
- **WR:** `mem_we`=1, `mem_din`=`wdata` → RESP.
- **MERGE:** `mem_we`=1. `mem_din`=`mem_spo` with the addressed lane(s) replaced by the low byte/half of `wdata`. Lane is `addr[1:0]` for a byte, `addr[1]` for a half; little-endian. → RESP.
- **RESP:** `rsp_valid[owner]`=1 for exactly one cycle.
  - Load result: `rsp_rdata` = lane extracted from `mem_spo`, sign-extended unless `unsigned`; the word is passed through for word size.
  - Store or error: `rsp_rdata`=0.
  - → IDLE. Update `last_grant` on every accepted request.
- **`mem_a` hold:** `mem_a` holds its value through RD, MERGE and RESP. It holds its last value in IDLE.
- **`mem_we`:** high only in WR or MERGE, for exactly one cycle per store.
- **No pipelining:** one outstanding request. A new request cannot be accepted in RESP.

## Timing
- Handshake in cycle T0.
  - Load: `rsp_valid` at T2.
  - Word store: `mem_we` at T1, `rsp_valid` at T2.
  - Sub-word store: read at T1, write at T2, `rsp_valid` at T3.
  - Misaligned: `rsp_valid` with `rsp_err` at T1.
- **Reset values:** `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `mem_we`=0, `mem_a`=0, `mem_din`=0, `req_ready`=0 while `rst` is high, state=IDLE, `last_grant`=1.
- **Reset mid-operation:** the request is dropped with no response. `mem_we` is 0 in the cycle after `rst` is sampled. A read-modify-write aborted in RD leaves the RAM unchanged.
- **Address wrap:** addresses at or above 2^(ADDR_W+2) cannot be expressed, so there is no wrap logic.
- **Ignored inputs:** a requester that drops `valid` without a handshake is ignored. Request inputs are don't-care after the handshake.

## Structure
- **Package `dram_ctrl_pkg`:** size enum (`SZ_B`, `SZ_H`, `SZ_W`), state enum, `ADDR_W`/`DATA_W` constants, and a request struct `{we, addr, size, unsigned, wdata}`.
- **Sub-module `dram_lane_unit`:** combinational. Inputs: word, `wdata`, offset, size, unsigned. Outputs: extracted load value and merged store word.
- **Top level:** holds the FSM, arbiter and latches.

## Test plan
- **Word round trip:** port 0 stores word 0xDEADBEEF @ byte 0x0010, then loads it → `mem_we` pulse at `mem_a`=0x0004; load returns 0xDEADBEEF at T2.
- **Sub-word merge and extend:** RAM word 4 = 0x11223344. Port 0 stores byte 0xAA @ 0x0012 → written word 0x11AA3344, `rsp_valid` at T3. Then a signed byte load @ 0x0012 → 0xFFFFFFAA; unsigned → 0x000000AA; signed half @ 0x0012 → 0x000011AA.
- **Round-robin:** both ports hold `valid` continuously → grants alternate 0,1,0,1; the first grant goes to port 0.
- **Misaligned:** half load @ 0x0001 → `rsp_err`=1, `rsp_rdata`=0 at T1; `mem_we` never asserted.
- **Reset mid-RMW:** assert `rst` in RD of a byte store → no `mem_we`, no `rsp_valid`; RAM word unchanged; next request serviced normally.
- **Port 1 routing:** port 1 loads word @ 0x0040 → only `rsp_valid[1]` pulses; `req_ready[0]` stays low throughout.

Source files
------------

// File: rtl/dram_ctrl_pkg.sv
// rtl/dram_ctrl_pkg.sv - shared types and constants for the data RAM arbiter
package dram_ctrl_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        MERGE,
        RESP
    } state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W+1:0] addr;
        size_e             size;
        logic              is_unsigned;
        logic [DATA_W-1:0] wdata;
    } req_t;

    // Encoding 11 has no meaning of its own and behaves as a word access.
    function automatic size_e norm_size(input logic [1:0] raw);
        return (raw == 2'b11) ? SZ_W : size_e'(raw);
    endfunction

    function automatic logic misaligned(input size_e sz, input logic [1:0] off);
        case (sz)
            SZ_H:    return off[0];
            SZ_W:    return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dram_arbiter_if.sv
// rtl/dram_arbiter_if.sv - requester, response and RAM signals of the arbiter
interface dram_arbiter_if;
    import dram_ctrl_pkg::*;

    logic [1:0]                   req_valid;
    logic [1:0]                   req_ready;
    logic [1:0]                   req_we;
    logic [1:0][ADDR_W+1:0]       req_addr;
    logic [1:0][1:0]              req_size;
    logic [1:0]                   req_unsigned;
    logic [1:0][DATA_W-1:0]       req_wdata;

    logic [1:0]                   rsp_valid;
    logic [DATA_W-1:0]            rsp_rdata;
    logic                         rsp_err;

    logic [ADDR_W-1:0]            mem_a;
    logic                         mem_we;
    logic [DATA_W-1:0]            mem_din;
    logic [DATA_W-1:0]            mem_spo;

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, mem_spo,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_a, mem_we, mem_din
    );

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, mem_spo,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_a, mem_we, mem_din
    );

endinterface

// File: rtl/dram_lane_unit.sv
// rtl/dram_lane_unit.sv - little-endian lane extract/extend and store merge
module dram_lane_unit
    import dram_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        offset,
    input  size_e             size,
    input  logic              is_unsigned,
    output logic [DATA_W-1:0] load_val,
    output logic [DATA_W-1:0] merge_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word[{offset, 3'b000} +: 8];
    assign half_sel = word[{offset[1], 4'b0000} +: 16];

    always_comb begin
        load_val = word;
        case (size)
            SZ_B:    load_val = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SZ_H:    load_val = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_val = word;
        endcase
    end

    always_comb begin
        merge_word = word;
        case (size)
            SZ_B:    merge_word[{offset, 3'b000} +: 8]     = wdata[7:0];
            SZ_H:    merge_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            default: merge_word = wdata;
        endcase
    end

endmodule

// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - two-port round-robin arbiter and access sequencer for the data RAM
module dram_arbiter
    import dram_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    dram_arbiter_if.slave bus
);

    state_e            state_q, state_d;
    req_t              req_q, req_in;
    logic              owner_q, last_grant_q, err_q;
    logic              grant, accept, req_mis;
    logic [DATA_W-1:0] load_val, merge_word;

    // A lone requester always wins; on a tie the port that lost last time goes.
    always_comb begin
        if (bus.req_valid == 2'b11) grant = ~last_grant_q;
        else                        grant = bus.req_valid[1];
    end

    always_comb begin
        req_in.we          = bus.req_we[grant];
        req_in.addr        = bus.req_addr[grant];
        req_in.size        = norm_size(bus.req_size[grant]);
        req_in.is_unsigned = bus.req_unsigned[grant];
        req_in.wdata       = bus.req_wdata[grant];
    end

    assign req_mis = misaligned(req_in.size, req_in.addr[1:0]);
    assign accept  = (state_q == IDLE) && (bus.req_valid != 2'b00) && !rst;

    always_comb begin
        bus.req_ready = 2'b00;
        if (accept) bus.req_ready[grant] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_mis)                               state_d = RESP;
                    else if (req_in.we && req_in.size == SZ_W) state_d = WR;
                    else                                       state_d = RD;
                end
            end
            RD:        state_d = req_q.we ? MERGE : RESP;
            WR, MERGE: state_d = RESP;
            RESP:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            req_q        <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                req_q        <= req_in;
                owner_q      <= grant;
                last_grant_q <= grant;
                err_q        <= req_mis;
            end
        end
    end

    dram_lane_unit u_lane (
        .word        (bus.mem_spo),
        .wdata       (req_q.wdata),
        .offset      (req_q.addr[1:0]),
        .size        (req_q.size),
        .is_unsigned (req_q.is_unsigned),
        .load_val    (load_val),
        .merge_word  (merge_word)
    );

    // The RAM address comes straight from the latched request, so it stays put
    // from RD through RESP and keeps its last value while idle.
    always_comb begin
        bus.mem_a     = req_q.addr[ADDR_W+1:2];
        bus.mem_we    = 1'b0;
        bus.mem_din   = '0;
        bus.rsp_valid = 2'b00;
        bus.rsp_rdata = '0;
        bus.rsp_err   = 1'b0;
        case (state_q)
            WR: begin
                bus.mem_we  = !rst;
                bus.mem_din = req_q.wdata;
            end
            MERGE: begin
                bus.mem_we  = !rst;
                bus.mem_din = merge_word;
            end
            RESP: begin
                bus.rsp_valid[owner_q] = !rst;
                bus.rsp_err            = err_q;
                if (!err_q && !req_q.we) bus.rsp_rdata = load_val;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - self-checking bench for dram_arbiter with RAM model and response scoreboard
module tb_dram_arbiter;
    import dram_ctrl_pkg::*;

    typedef struct {
        logic [1:0]  vld;
        logic [31:0] rd;
        logic        err;
        int          at;
    } exp_t;

    typedef struct {
        logic        p;
        logic        we;
        logic [17:0] addr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          lat;
        int          widx;
        logic [31:0] exp_word;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic preload;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dram_arbiter_if bus();

    dram_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] ram [0:(1<<ADDR_W)-1];

    always @(posedge clk) begin
        if (preload) begin
            ram[4]  <= 32'h0;
            ram[5]  <= 32'h0;
            ram[6]  <= 32'h01020304;
            ram[8]  <= 32'h8BADF00D;
            ram[16] <= 32'hCAFEF00D;
        end else if (bus.mem_we) begin
            ram[bus.mem_a] <= bus.mem_din;
        end
        bus.mem_spo <= ram[bus.mem_a];
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus.rsp_valid != 2'b00) begin
            exp_t e;
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'(bus.rsp_valid), 32'h0);
            end else begin
                e = sb.pop_front();
                chk("rsp_port", 32'(bus.rsp_valid), 32'(e.vld));
                chk("rsp_rdata", bus.rsp_rdata, e.rd);
                chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                chk("rsp_cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    // Called and returns one time unit after a rising edge.
    task automatic do_req(input vec_t v);
        int   waited, we_cnt, other_rdy;
        logic done;
        exp_t e;
        bus.req_we[v.p]       = v.we;
        bus.req_addr[v.p]     = v.addr;
        bus.req_size[v.p]     = v.sz;
        bus.req_unsigned[v.p] = v.uns;
        bus.req_wdata[v.p]    = v.wd;
        bus.req_valid[v.p]    = 1'b1;
        waited    = 0;
        other_rdy = 0;
        #1;
        while (!bus.req_ready[v.p] && waited < 20) begin
            other_rdy += int'(bus.req_ready[~v.p]);
            @(posedge clk);
            #2;
            waited++;
        end
        chk("grant_seen", 32'(bus.req_ready[v.p]), 32'h1);
        e.vld = v.p ? 2'b10 : 2'b01;
        e.rd  = v.exp_rd;
        e.err = v.exp_err;
        e.at  = cyc + v.lat;
        if (bus.req_ready[v.p]) sb.push_back(e);
        other_rdy += int'(bus.req_ready[~v.p]);
        @(posedge clk);
        #1;
        bus.req_valid[v.p] = 1'b0;
        we_cnt = 0;
        done   = 1'b0;
        for (int k = 0; k < 8 && !done; k++) begin
            we_cnt    += int'(bus.mem_we);
            other_rdy += int'(bus.req_ready[~v.p]);
            if (bus.rsp_valid != 2'b00) begin
                done = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        chk("rsp_seen", 32'(done), 32'h1);
        chk("mem_we_pulses", 32'(we_cnt), (v.we && !v.exp_err) ? 32'h1 : 32'h0);
        chk("other_port_ready", 32'(other_rdy), 32'h0);
        if (v.widx >= 0) chk("ram_word", ram[16'(v.widx)], v.exp_word);
    endtask

    vec_t vt [18];

    initial begin
        int   waited, n_g, rst_we, rst_rsp;
        logic g;
        exp_t e;

        vt[0]  = '{1'b0, 1'b1, 18'h10, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0, 2, 4, 32'hDEADBEEF};
        vt[1]  = '{1'b0, 1'b0, 18'h10, 2'b10, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 2, -1, 32'h0};
        vt[2]  = '{1'b0, 1'b1, 18'h10, 2'b10, 1'b0, 32'h11223344, 32'h0,        1'b0, 2, 4, 32'h11223344};
        vt[3]  = '{1'b0, 1'b1, 18'h12, 2'b00, 1'b0, 32'h123456AA, 32'h0,        1'b0, 3, 4, 32'h11AA3344};
        vt[4]  = '{1'b0, 1'b0, 18'h12, 2'b00, 1'b0, 32'h0,        32'hFFFFFFAA, 1'b0, 2, -1, 32'h0};
        vt[5]  = '{1'b0, 1'b0, 18'h12, 2'b00, 1'b1, 32'h0,        32'h000000AA, 1'b0, 2, -1, 32'h0};
        vt[6]  = '{1'b0, 1'b0, 18'h12, 2'b01, 1'b0, 32'h0,        32'h000011AA, 1'b0, 2, -1, 32'h0};
        vt[7]  = '{1'b0, 1'b0, 18'h01, 2'b01, 1'b0, 32'h0,        32'h0,        1'b1, 1, -1, 32'h0};
        vt[8]  = '{1'b0, 1'b0, 18'h02, 2'b10, 1'b0, 32'h0,        32'h0,        1'b1, 1, -1, 32'h0};
        vt[9]  = '{1'b0, 1'b1, 18'h13, 2'b11, 1'b0, 32'h00000055, 32'h0,        1'b1, 1, 4, 32'h11AA3344};
        vt[10] = '{1'b0, 1'b1, 18'h16, 2'b01, 1'b0, 32'hFFFF5678, 32'h0,        1'b0, 3, 5, 32'h56780000};
        vt[11] = '{1'b0, 1'b0, 18'h16, 2'b01, 1'b0, 32'h0,        32'h00005678, 1'b0, 2, -1, 32'h0};
        vt[12] = '{1'b0, 1'b0, 18'h17, 2'b00, 1'b0, 32'h0,        32'h00000056, 1'b0, 2, -1, 32'h0};
        vt[13] = '{1'b0, 1'b0, 18'h14, 2'b11, 1'b0, 32'h0,        32'h56780000, 1'b0, 2, -1, 32'h0};
        vt[14] = '{1'b0, 1'b1, 18'h13, 2'b00, 1'b0, 32'h00000080, 32'h0,        1'b0, 3, 4, 32'h80AA3344};
        vt[15] = '{1'b0, 1'b0, 18'h13, 2'b00, 1'b0, 32'h0,        32'hFFFFFF80, 1'b0, 2, -1, 32'h0};
        vt[16] = '{1'b0, 1'b0, 18'h12, 2'b01, 1'b1, 32'h0,        32'h000080AA, 1'b0, 2, -1, 32'h0};
        vt[17] = '{1'b0, 1'b0, 18'h12, 2'b01, 1'b0, 32'h0,        32'hFFFF80AA, 1'b0, 2, -1, 32'h0};

        // Reset: requests held valid must not be acknowledged.
        rst              = 1'b1;
        preload          = 1'b1;
        bus.req_valid    = 2'b11;
        bus.req_we       = 2'b00;
        bus.req_addr     = '0;
        bus.req_size     = '0;
        bus.req_unsigned = 2'b00;
        bus.req_wdata    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
        chk("rst_mem_a", 32'(bus.mem_a), 32'h0);
        chk("rst_mem_din", bus.mem_din, 32'h0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
        bus.req_valid = 2'b00;
        preload       = 1'b0;
        rst           = 1'b0;
        @(posedge clk);
        #1;

        // Round-robin with both ports continuously valid.
        bus.req_size    = {2'b10, 2'b10};
        bus.req_addr[0] = 18'h20;
        bus.req_addr[1] = 18'h40;
        bus.req_valid   = 2'b11;
        n_g = 0;
        for (int k = 0; k < 40 && n_g < 4; k++) begin
            #1;
            if (bus.req_ready != 2'b00) begin
                g = bus.req_ready[1];
                chk("rr_onehot", 32'($countones(bus.req_ready)), 32'h1);
                chk("rr_grant", 32'(g), 32'(n_g % 2));
                e.vld = (n_g % 2 == 1) ? 2'b10 : 2'b01;
                e.rd  = (n_g % 2 == 1) ? 32'hCAFEF00D : 32'h8BADF00D;
                e.err = 1'b0;
                e.at  = cyc + 2;
                sb.push_back(e);
                n_g++;
            end
            @(posedge clk);
            #1;
        end
        bus.req_valid = 2'b00;
        chk("rr_grants", 32'(n_g), 32'h4);
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) do_req(vt[i]);

        // Reset during the read phase of a byte store.
        bus.req_we[0]    = 1'b1;
        bus.req_addr[0]  = 18'h18;
        bus.req_size[0]  = 2'b00;
        bus.req_wdata[0] = 32'h000000EE;
        bus.req_valid[0] = 1'b1;
        waited = 0;
        #1;
        while (!bus.req_ready[0] && waited < 20) begin
            @(posedge clk);
            #2;
            waited++;
        end
        chk("rmw_grant", 32'(bus.req_ready[0]), 32'h1);
        @(posedge clk);
        #1;
        bus.req_valid[0] = 1'b0;
        rst     = 1'b1;
        rst_we  = int'(bus.mem_we);
        rst_rsp = int'(bus.rsp_valid != 2'b00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rst_we  += int'(bus.mem_we);
            rst_rsp += int'(bus.rsp_valid != 2'b00);
            @(posedge clk);
            #1;
        end
        chk("rmw_abort_we", 32'(rst_we), 32'h0);
        chk("rmw_abort_rsp", 32'(rst_rsp), 32'h0);
        chk("rmw_abort_ram", ram[6], 32'h01020304);
        do_req('{1'b0, 1'b0, 18'h18, 2'b10, 1'b0, 32'h0, 32'h01020304, 1'b0, 2, -1, 32'h0});

        // Port 1 routing.
        do_req('{1'b1, 1'b0, 18'h40, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0, 2, -1, 32'h0});

        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
